// File: rtl/handshake_axis_read_mux.sv
// handshake_axis_read_mux: arbitrates N kernel load channels onto a single AXI-Stream
// request stream and routes the in-order payload stream back to the requesting channel.
// A tag FIFO records which channel issued each outstanding request.
// Optional feature: define HS_AXIS_RD_PL_REG_EN to insert a one-entry payload register
// (1-cycle payload-to-channel latency); the default build is a combinational pass-through.
module handshake_axis_read_mux #(
    parameter int unsigned ADDR_WIDTH      = 4,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned N_CHANNELS      = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ADDR_WIDTH-1:0]              ldAddr       [N_CHANNELS],
    input  logic                               ldAddr_valid [N_CHANNELS],
    output logic                               ldAddr_ready [N_CHANNELS],
    output logic [DATA_WIDTH-1:0]              ldData       [N_CHANNELS],
    output logic                               ldData_valid [N_CHANNELS],
    input  logic                               ldData_ready [N_CHANNELS],
    output logic [ADDR_WIDTH-1:0]              m_axis_req_tdata,
    output logic                               m_axis_req_tvalid,
    input  logic                               m_axis_req_tready,
    output logic                               m_axis_req_tlast,
    input  logic [DATA_WIDTH-1:0]              s_axis_pl_tdata,
    input  logic                               s_axis_pl_tvalid,
    output logic                               s_axis_pl_tready,
    input  logic                               s_axis_pl_tlast,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

    localparam int unsigned CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [CH_W-1:0]  last_grant;
    logic [CH_W-1:0]  winner;
    logic             found;
    logic             loadable;
    logic             accept;

    logic [CH_W-1:0]  tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CH_W-1:0]  head;
    logic             non_empty;
    logic             push;
    logic             pop;

    // Every request is one beat, so tlast is not tracked separately.
    logic unused_tlast;
    assign unused_tlast = s_axis_pl_tlast;

    assign outstanding      = count;
    assign m_axis_req_tlast = m_axis_req_tvalid;
    assign non_empty        = (count != '0);
    assign head             = tag_mem[rd_ptr];

    // Full check uses the registered count: no push bypass when full.
    assign loadable = !reset && (!m_axis_req_tvalid || m_axis_req_tready) &&
                      (count < CNT_W'(MAX_OUTSTANDING));
    assign accept   = found && loadable;
    assign push     = accept;
    assign pop      = s_axis_pl_tvalid && s_axis_pl_tready;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 1; i <= N_CHANNELS; i++) begin
            idx = (int'(last_grant) + i) % N_CHANNELS;
            if (!found && ldAddr_valid[idx]) begin
                found  = 1'b1;
                winner = CH_W'(idx);
            end
        end
    end

    // Only the winner sees ready, and only when the request slot can take it.
    always_comb begin
        for (int unsigned i = 0; i < N_CHANNELS; i++) begin
            ldAddr_ready[i] = accept && (winner == CH_W'(i));
        end
    end

    // Request slot valid flag and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_req_tvalid <= 1'b0;
            last_grant        <= CH_W'(N_CHANNELS - 1);
        end else if (accept) begin
            m_axis_req_tvalid <= 1'b1;
            last_grant        <= winner;
        end else if (m_axis_req_tready) begin
            m_axis_req_tvalid <= 1'b0;
        end
    end

    // Request address: data path, loaded only on accept so it holds under backpressure.
    always_ff @(posedge clk) begin
        if (accept) begin
            m_axis_req_tdata <= ldAddr[winner];
        end
    end

    // Tag FIFO storage.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= winner;
        end
    end

    // Tag FIFO pointers and occupancy; pointers wrap naturally (depth is a power of 2).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

`ifdef HS_AXIS_RD_PL_REG_EN
    logic                  reg_valid;
    logic [DATA_WIDTH-1:0] reg_data;
    logic [CH_W-1:0]       reg_ch;

    assign s_axis_pl_tready = !reset && non_empty && (!reg_valid || ldData_ready[reg_ch]);

    // Payload register occupancy: refilled on pop, drained when its channel takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_valid <= 1'b0;
        end else if (pop) begin
            reg_valid <= 1'b1;
        end else if (reg_valid && ldData_ready[reg_ch]) begin
            reg_valid <= 1'b0;
        end
    end

    // Payload register contents (data path, not reset).
    always_ff @(posedge clk) begin
        if (pop) begin
            reg_data <= s_axis_pl_tdata;
            reg_ch   <= head;
        end
    end

    // Registered payload steered to the captured channel, data broadcast to all.
    always_comb begin
        for (int unsigned i = 0; i < N_CHANNELS; i++) begin
            ldData[i]       = reg_data;
            ldData_valid[i] = !reset && reg_valid && (reg_ch == CH_W'(i));
        end
    end
`else
    assign s_axis_pl_tready = !reset && non_empty && ldData_ready[head];

    // Combinational pass-through to the FIFO-head channel, data broadcast to all.
    always_comb begin
        for (int unsigned i = 0; i < N_CHANNELS; i++) begin
            ldData[i]       = s_axis_pl_tdata;
            ldData_valid[i] = !reset && s_axis_pl_tvalid && non_empty && (head == CH_W'(i));
        end
    end
`endif

endmodule

// File: doc/handshake_axis_read_mux.md
HANDSHAKE_AXIS_READ_MUX -- requirements
Module: handshake_axis_read_mux

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: load address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload width in bits.
REQ-003 SHALL have parameter N_CHANNELS, default 2, legal range 1..8: number of kernel load channels.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, a power of 2 in range 2..16: depth of the in-flight tag FIFO.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port ldAddr, input, unpacked [N_CHANNELS] x ADDR_WIDTH: per-channel load address.
REQ-008 SHALL have ports ldAddr_valid (input) and ldAddr_ready (output), each unpacked [N_CHANNELS] x 1: per-channel address handshake.
REQ-009 SHALL have port ldData, output, unpacked [N_CHANNELS] x DATA_WIDTH: per-channel returned data.
REQ-010 SHALL have ports ldData_valid (output) and ldData_ready (input), each unpacked [N_CHANNELS] x 1: per-channel data handshake.
REQ-011 SHALL have ports m_axis_req_tdata (output, ADDR_WIDTH), m_axis_req_tvalid (output, 1), m_axis_req_tready (input, 1) and m_axis_req_tlast (output, 1): the memory request stream.
REQ-012 SHALL have ports s_axis_pl_tdata (input, DATA_WIDTH), s_axis_pl_tvalid (input, 1), s_axis_pl_tready (output, 1) and s_axis_pl_tlast (input, 1): the memory payload stream.
REQ-013 SHALL have port outstanding, output, $clog2(MAX_OUTSTANDING)+1 bits: current tag FIFO occupancy.

Function
REQ-014 SHALL register the request slot: m_axis_req_tvalid and m_axis_req_tdata are flops.
REQ-015 SHALL treat the slot as loadable when (!m_axis_req_tvalid || m_axis_req_tready) && outstanding < MAX_OUTSTANDING.
REQ-016 SHALL grant a round-robin winner among channels with ldAddr_valid set, searching from last_grant+1 modulo N_CHANNELS.
REQ-017 SHALL drive ldAddr_ready high only for the winner, and only while the slot is loadable; all other ready bits are 0.
REQ-018 SHALL, on an accept, load the slot with the winner's ldAddr, push the winner's index into the tag FIFO, and set last_grant to the winner.
REQ-019 SHALL hold m_axis_req_tlast at 1 whenever m_axis_req_tvalid is 1, because every request is a single beat.
REQ-020 SHALL keep m_axis_req_tdata stable while m_axis_req_tvalid && !m_axis_req_tready.
REQ-021 SHALL route payload in order: the tag FIFO head selects the destination channel h.
REQ-022 SHALL, in pass-through mode, set ldData_valid[h] = s_axis_pl_tvalid && FIFO non-empty, with all other ldData_valid bits 0.
REQ-023 SHALL, in pass-through mode, set s_axis_pl_tready = FIFO non-empty && ldData_ready[h].
REQ-024 SHALL broadcast ldData to all channels from the payload path.
REQ-025 SHALL pop the tag FIFO on each payload handshake.
REQ-026 SHALL hold s_axis_pl_tready at 0 while the FIFO is empty, so stray payload is never consumed.
REQ-027 SHALL ignore s_axis_pl_tlast.
REQ-028 SHALL, on a simultaneous push and pop, leave outstanding unchanged; the full check uses the registered count, so there is no bypass at full.
REQ-029 SHALL wrap the tag FIFO pointers modulo MAX_OUTSTANDING.
REQ-030 SHALL make N_CHANNELS=1 degenerate to a single pass-through channel with the same timing.

Reset
REQ-031 SHALL, while reset is high at a rising clk edge, clear m_axis_req_tvalid, the FIFO pointers and outstanding, and set last_grant to N_CHANNELS-1 so channel 0 has first priority.
REQ-032 SHALL hold all ldAddr_ready, all ldData_valid and s_axis_pl_tready at 0 while reset is high.
REQ-033 SHALL drop in-flight tags on a mid-operation reset; any payload still owed is not consumed after reset.
REQ-034 SHALL not reset data-path registers (m_axis_req_tdata, payload data register).

Configuration
REQ-035 SHALL, when macro HS_AXIS_RD_PL_REG_EN is defined, insert a single-entry payload register holding data and channel index.
REQ-036 SHALL, with HS_AXIS_RD_PL_REG_EN defined, set s_axis_pl_tready = FIFO non-empty && (!reg_valid || ldData_ready[reg_ch]).
REQ-037 SHALL, with HS_AXIS_RD_PL_REG_EN defined, drive ldData_valid[reg_ch] from reg_valid, giving 1 cycle payload-to-channel latency, and clear reg_valid on reset.
REQ-038 SHALL, without HS_AXIS_RD_PL_REG_EN, use the combinational pass-through of REQ-022/REQ-023 with 0-cycle latency.

Verification
REQ-039 SHALL cover: ch0 and ch1 valid continuously, addresses 0x3 and 0x5, req_tready=1 -> requests alternate 0x3, 0x5, 0x3, starting with ch0 after reset.
REQ-040 SHALL cover: MAX_OUTSTANDING=4, no payload returned, 6 address requests -> exactly 4 accepted, outstanding=4, ldAddr_ready=0 thereafter.
REQ-041 SHALL cover: grants order ch1, ch0, ch1, then payload 0xA, 0xB, 0xC -> ch1 receives 0xA, ch0 receives 0xB, ch1 receives 0xC.
REQ-042 SHALL cover: head channel ldData_ready=0 for 3 cycles -> s_axis_pl_tready=0 for those cycles and no data loss.
REQ-043 SHALL cover: s_axis_pl_tvalid=1 with the FIFO empty -> s_axis_pl_tready=0 and all ldData_valid=0.
REQ-044 SHALL cover: reset asserted with outstanding=3 -> next cycle outstanding=0, m_axis_req_tvalid=0, and in-flight payload is not accepted.
